// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and the transmitter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_uart_data_w   = 8;
    localparam int c_uart_baud_div = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Bit-period counter; tick marks the last clk of each serial bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w   = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BAUD_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (clear || (r_count == c_cnt_max)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = !clear && (r_count == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter pulling characters from an external FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = c_uart_data_w,
    parameter int BAUD_DIV  = c_uart_baud_div,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int                 c_bit_max   = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int                 c_bit_w     = (c_bit_max > 1) ? $clog2(c_bit_max) : 1;
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_W - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);

    tx_state_t           r_state;
    tx_state_t           w_state_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [c_bit_w-1:0]  w_bit_cnt_next;
    logic                r_parity;
    logic                w_parity_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_rd_en;
    logic                w_rd_en_next;
    logic                w_baud_clear;
    logic                w_tick;

    assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (w_baud_clear),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
            r_rd_en   <= w_rd_en_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_rd_en_next   = 1'b0;
        w_tx_next      = 1'b1;

        case (r_state)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    w_state_next = FETCH;
                    w_rd_en_next = 1'b1;
                end
            end
            FETCH: begin
                w_state_next   = START;
                w_shift_next   = fifo_data;
                w_parity_next  = ^fifo_data;
                w_bit_cnt_next = '0;
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_data_last) begin
                        w_bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                        end else begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_stop_last) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is going next
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == STOP) && w_tick && (r_bit_cnt == c_stop_last);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo across parity/stop-bit variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_baud  = 4;
    localparam int c_ni    = 3;
    localparam int c_depth = 256;

    logic       clk     = 1'b0;
    logic       n_reset = 1'b1;
    logic       tx_en   = 1'b0;
    logic       fifo_empty [c_ni];
    logic [7:0] fifo_data  [c_ni];
    logic       fifo_rd_en [c_ni];
    logic       tx         [c_ni];
    logic       busy       [c_ni];
    logic       frame_done [c_ni];

    logic [7:0] fifo_mem [c_ni][c_depth];
    logic [7:0] exp_mem  [c_ni][c_depth];
    int wr_ptr [c_ni];
    int rd_ptr [c_ni];
    int exp_wr [c_ni];
    int exp_rd [c_ni];
    int rd_cnt [c_ni];
    int frames [c_ni];
    int starts [c_ni];
    int start_cyc [c_ni];
    int last_len [c_ni];
    int last_gap [c_ni];
    int stray_done [c_ni];
    int cyc;
    int checks;
    int fails;
    int n_pushed;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_ni; g++) begin : g_fifo
        assign fifo_empty[g] = (rd_ptr[g] == wr_ptr[g]);
        assign fifo_data[g]  = fifo_mem[g][rd_ptr[g] % c_depth];
    end

    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(c_baud), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]),
        .busy(busy[0]), .frame_done(frame_done[0]));

    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(c_baud), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]),
        .busy(busy[1]), .frame_done(frame_done[1]));

    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(c_baud), .PARITY_EN(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en), .fifo_empty(fifo_empty[2]),
        .fifo_data(fifo_data[2]), .fifo_rd_en(fifo_rd_en[2]), .tx(tx[2]),
        .busy(busy[2]), .frame_done(frame_done[2]));

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instance 0: no parity, 1 stop; 1: parity, 1 stop; 2: parity, 2 stop
    function automatic int frame_len(input int i);
        return c_baud * (1 + 8 + ((i > 0) ? 1 : 0) + ((i == 2) ? 2 : 1));
    endfunction

    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (i > 0 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < c_ni; i++) begin
            fifo_mem[i][wr_ptr[i] % c_depth] = b;
            wr_ptr[i]++;
            exp_mem[i][exp_wr[i] % c_depth] = b;
            exp_wr[i]++;
        end
        n_pushed++;
    endtask

    // Decodes each serial frame against the expected-byte queue head.
    task automatic monitor(input int i);
        bit         in_frame = 1'b0;
        bit         pend     = 1'b0;
        int         owed     = 0;
        int         t        = 0;
        int         tx_err   = 0;
        int         ctl_err  = 0;
        int         rd_cyc   = -10;
        int         done_cyc = -100;
        int         len;
        logic [7:0] b = 8'h00;
        len = frame_len(i);
        forever begin
            @(negedge clk);
            if (pend) rd_ptr[i] = rd_ptr[i] + 1;
            pend = (fifo_rd_en[i] === 1'b1);
            if (!n_reset) begin
                exp_rd[i] += owed;
                owed     = 0;
                in_frame = 1'b0;
            end else begin
                if (pend) begin
                    rd_cnt[i]++;
                    owed++;
                    rd_cyc = cyc;
                end
                if (frame_done[i] === 1'b1) begin
                    if (!in_frame) stray_done[i]++;
                    last_len[i] = cyc - start_cyc[i] + 1;
                    done_cyc    = cyc;
                end
                if (!in_frame && tx[i] === 1'b0) begin
                    in_frame = 1'b1;
                    t        = 0;
                    tx_err   = 0;
                    ctl_err  = 0;
                    starts[i]++;
                    start_cyc[i] = cyc;
                    last_gap[i]  = cyc - done_cyc;
                    check("rd_to_start", cyc - rd_cyc, 1);
                    check("frame_expected", longint'(exp_rd[i] < exp_wr[i]), 1);
                    b = exp_mem[i][exp_rd[i] % c_depth];
                end
                if (in_frame) begin
                    if (tx[i] !== exp_bit(i, b, t / c_baud)) tx_err++;
                    if (frame_done[i] !== (t == len - 1)) ctl_err++;
                    if (busy[i] !== 1'b1) ctl_err++;
                    t++;
                    if (t == len) begin
                        check("tx_wave", tx_err, 0);
                        check("frame_ctl", ctl_err, 0);
                        in_frame = 1'b0;
                        frames[i]++;
                        exp_rd[i]++;
                        owed--;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = 1'b1;
            for (int i = 0; i < c_ni; i++) begin
                if (exp_rd[i] != exp_wr[i] || busy[i] !== 1'b0 || rd_ptr[i] != wr_ptr[i]) done = 1'b0;
            end
        end
        check(name, longint'(done), 1);
    endtask

    task automatic wait_start_offset(input int base, input int offset, input int budget);
        int n = 0;
        while (starts[0] <= base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", longint'(starts[0] > base), 1);
        while (cyc < start_cyc[0] + offset && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int bad;
        int base;
        int rd0;
        int fr0;
        checks   = 0;
        fails    = 0;
        cyc      = 0;
        n_pushed = 0;
        for (int i = 0; i < c_ni; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
            rd_cnt[i] = 0; frames[i] = 0; starts[i] = 0; start_cyc[i] = 0;
            last_len[i] = 0; last_gap[i] = 0; stray_done[i] = 0;
        end
        fork
            forever @(posedge clk) cyc++;
            monitor(0);
            monitor(1);
            monitor(2);
        join_none

        #1 n_reset = 1'b0;
        #2;
        for (int i = 0; i < c_ni; i++) begin
            check("reset_tx", tx[i], 1);
            check("reset_busy", busy[i], 0);
            check("reset_rd_en", fifo_rd_en[i], 0);
            check("reset_frame_done", frame_done[i], 0);
        end
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        // Empty FIFO with tx_en high, then data present with tx_en low
        tx_en = 1'b1;
        bad   = 0;
        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < c_ni; i++)
                if (fifo_rd_en[i] !== 1'b0 || tx[i] !== 1'b1 || busy[i] !== 1'b0) bad++;
        end
        check("empty_idle", bad, 0);
        tx_en = 1'b0;
        push_byte(8'h55);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            for (int i = 0; i < c_ni; i++)
                if (fifo_rd_en[i] !== 1'b0 || tx[i] !== 1'b1 || busy[i] !== 1'b0) bad++;
        end
        check("tx_en_low_idle", bad, 0);

        tx_en = 1'b1;
        wait_drain("drain_55", 200);
        check("len_55_plain", last_len[0], 40);
        for (int i = 0; i < c_ni; i++) begin
            check("rd_cnt_55", rd_cnt[i], 1);
            check("len_55", last_len[i], frame_len(i));
        end

        push_byte(8'hA7);
        wait_drain("drain_a7", 200);
        check("len_a7_parity", last_len[1], 44);
        check("frames_a7", frames[1], 2);

        // Back-to-back pair
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_drain("drain_b2b", 300);
        for (int i = 0; i < c_ni; i++) begin
            check("rd_cnt_b2b", rd_cnt[i], 4);
            check("b2b_gap", last_gap[i], 3);
        end

        // tx_en dropped during data bit 3
        base = starts[0];
        for (int k = 0; k < 3; k++) push_byte(8'($urandom_range(0, 255)));
        wait_start_offset(base, c_baud * 4 + 1, 200);
        tx_en = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 0; i < c_ni; i++) begin
            check("txen_drop_rd", rd_cnt[i], 5);
            check("txen_drop_frames", frames[i], 5);
            check("txen_drop_busy", busy[i], 0);
        end
        tx_en = 1'b1;
        wait_drain("drain_txen", 400);

        // Asynchronous reset during data bit 4
        rd0  = rd_cnt[0];
        fr0  = frames[0];
        base = starts[0];
        push_byte(8'h3C);
        push_byte(8'hC3);
        wait_start_offset(base, c_baud * 5 + 1, 200);
        #2 n_reset = 1'b0;
        #1;
        for (int i = 0; i < c_ni; i++) begin
            check("midreset_tx", tx[i], 1);
            check("midreset_busy", busy[i], 0);
            check("midreset_rd_en", fifo_rd_en[i], 0);
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        wait_drain("drain_reset", 400);
        check("reset_rd_cnt", rd_cnt[0] - rd0, 2);
        check("reset_frames", frames[0] - fr0, 1);

        // Randomised traffic with tx_en toggling
        for (int r = 0; r < 24; r++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            tx_en = ($urandom_range(0, 3) != 0);
            push_byte(8'($urandom_range(0, 255)));
        end
        tx_en = 1'b1;
        wait_drain("drain_random", 4000);
        for (int i = 0; i < c_ni; i++) begin
            check("final_rd_cnt", rd_cnt[i], n_pushed);
            check("final_frames", frames[i], n_pushed - 1);
            check("stray_frame_done", stray_done[i], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning character width in bits.
REQ-002 The module SHALL have parameter BAUD_DIV, default 434, meaning clk cycles per serial bit (legal range >= 2).
REQ-003 The module SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-005 The module SHALL have port clk  input  1  system clock, rising edge.
REQ-006 The module SHALL have port n_reset  input  1  asynchronous active-low reset.
REQ-007 The module SHALL have port tx_en  input  1  permits a new frame to start.
REQ-008 The module SHALL have port fifo_empty  input  1  the source FIFO has no data.
REQ-009 The module SHALL have port fifo_data  input  DATA_W  FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 The module SHALL have port fifo_rd_en  output  1  one-cycle FIFO read strobe, registered.
REQ-011 The module SHALL have port tx  output  1  serial line, idle high, registered.
REQ-012 The module SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The module SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-015 In IDLE with tx_en=1 and fifo_empty=0, fifo_rd_en SHALL be high for exactly the next cycle and the state SHALL become FETCH.
REQ-016 In FETCH, fifo_data SHALL be captured into the shift register and the state SHALL become START, with the baud counter cleared.
REQ-017 Each of START, each DATA bit, PARITY and each STOP bit SHALL hold tx constant for exactly BAUD_DIV clk cycles.
REQ-018 tx SHALL be 0 in START, data LSB first in DATA, the XOR of all data bits in PARITY, and 1 in STOP.
REQ-019 PARITY SHALL be skipped (DATA goes to STOP) when PARITY_EN=0.
REQ-020 The baud counter SHALL be $clog2(BAUD_DIV) bits wide, count 0..BAUD_DIV-1, and wrap to 0 at each bit boundary.
REQ-021 The bit counter SHALL count 0..DATA_W-1 in DATA, then 0..STOP_BITS-1 in STOP.
REQ-022 After the final stop bit the state SHALL return to IDLE, with frame_done pulsed on that last cycle.
REQ-023 Back-to-back operation: the end of the stop bit to the start-bit falling edge SHALL be exactly 2 clk cycles (IDLE, FETCH).
REQ-024 fifo_empty=1 or tx_en=0 in IDLE SHALL keep fifo_rd_en=0 and tx=1 indefinitely.
REQ-025 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-026 fifo_empty and fifo_data SHALL be ignored outside IDLE and FETCH respectively.
REQ-027 No more than one FIFO read SHALL ever be issued per frame.

Reset
REQ-028 Asserting n_reset low SHALL immediately force state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, and both counters and the shift register to 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no further FIFO read; operation resumes from IDLE on the first rising clk after n_reset goes high.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and the default baud/width constants shared with the UART receiver.
REQ-031 The baud counter SHALL be a sub-module, uart_baud_gen, with clear input and tick output; the remaining logic SHALL be one FSM plus datapath in uart_tx_fifo.

Verification (BAUD_DIV=4, DATA_W=8, STOP_BITS=1 unless stated)
REQ-032 FIFO holds 0x55, PARITY_EN=0, tx_en=1 -> one fifo_rd_en pulse; tx=0,1,0,1,0,1,0,1,0,1, each held 4 cycles; frame_done after 40 cycles.
REQ-033 PARITY_EN=1, byte 0xA7 -> data bits 1,1,1,0,0,1,0,1 then parity bit 1, then stop; total frame 44 cycles.
REQ-034 Two bytes 0x00 and 0xFF queued -> two rd_en pulses; the second start bit begins exactly 2 cycles after the first frame_done.
REQ-035 fifo_empty=1 for 100 cycles -> fifo_rd_en=0, tx=1, busy=0 throughout; tx_en dropped at data bit 3 -> frame completes, no further read.
REQ-036 n_reset pulsed low during data bit 4 -> tx=1 and busy=0 immediately with no clock; after release with the FIFO non-empty, a new frame starts with a single rd_en pulse.
